// File: rtl/bsg_nonsynth_clock_strobe_gen.sv
// Programmable strobe generator: emits a one-cycle tick every (period+1)
// cycles, a divided clock that toggles on each tick, and a running tick
// count. New periods are staged and take effect only at a wrap boundary.
module bsg_nonsynth_clock_strobe_gen #(
  parameter int unsigned width_p       = 8,
  parameter int unsigned init_period_p = 3,
  parameter int unsigned count_width_p = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  input  logic [width_p-1:0]       period_i,
  output logic                     ready_o,
  output logic                     tick_o,
  output logic                     div_clk_o,
  output logic [count_width_p-1:0] tick_count_o
);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    PENDING = 1'b1
  } state_e;

  state_e                   state_r;
  state_e                   state_n;
  logic [width_p-1:0]       period_r;
  logic [width_p-1:0]       cnt_r;
  logic [width_p-1:0]       pending_r;
  logic                     tick_r;
  logic                     div_r;
  logic [count_width_p-1:0] count_r;

  logic                     wrap_c;
  logic                     accept_c;
  logic                     load_c;

  // End of the current interval
  assign wrap_c = (cnt_r == period_r);

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= RUN;
    end else begin
      state_r <= state_n;
    end
  end

  // Next state: a staged period waits for the next wrap; any accept made
  // on a wrap edge in RUN lands in PENDING and so waits one full old period
  always_comb begin
    state_n = state_r;
    case (state_r)
      RUN:     if (accept_c) state_n = PENDING;
      PENDING: if (wrap_c)   state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  // Handshake and control strobes decoded from state
  always_comb begin
    ready_o  = 1'b0;
    accept_c = 1'b0;
    load_c   = 1'b0;
    ready_o  = (state_r == RUN) && !reset_i;
    accept_c = ready_o && v_i;
    load_c   = (state_r == PENDING) && wrap_c;
  end

  // Interval counter, staged period, tick/divider/count registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      period_r  <= width_p'(init_period_p);
      cnt_r     <= '0;
      pending_r <= '0;
      tick_r    <= 1'b0;
      div_r     <= 1'b0;
      count_r   <= '0;
    end else begin
      if (accept_c) begin
        pending_r <= period_i;
      end
      if (wrap_c) begin
        cnt_r   <= '0;
        tick_r  <= 1'b1;
        div_r   <= ~div_r;
        count_r <= count_r + count_width_p'(1);
        if (load_c) begin
          period_r <= pending_r;
        end
      end else begin
        cnt_r  <= cnt_r + width_p'(1);
        tick_r <= 1'b0;
      end
    end
  end

  assign tick_o       = tick_r;
  assign div_clk_o    = div_r;
  assign tick_count_o = count_r;

endmodule

// File: tb/tb_bsg_nonsynth_clock_strobe_gen.sv
// Directed bench for bsg_nonsynth_clock_strobe_gen with default parameters.
module tb_bsg_nonsynth_clock_strobe_gen;

  logic       clk_i;
  logic       reset_i;
  logic       v_i;
  logic [7:0] period_i;
  logic       ready_o;
  logic       tick_o;
  logic       div_clk_o;
  logic [7:0] tick_count_o;

  int checks;
  int errors;

  bsg_nonsynth_clock_strobe_gen #(
    .width_p      (8),
    .init_period_p(3),
    .count_width_p(8)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .v_i         (v_i),
    .period_i    (period_i),
    .ready_o     (ready_o),
    .tick_o      (tick_o),
    .div_clk_o   (div_clk_o),
    .tick_count_o(tick_count_o)
  );

  // 10-unit clock
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Two reset edges, then release; returns just before edge 1
  task automatic apply_reset();
    reset_i  = 1'b1;
    v_i      = 1'b0;
    period_i = 8'd0;
    step();
    step();
    reset_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset_i  = 1'b1;
    v_i      = 1'b0;
    period_i = 8'd0;
    step();
    step();
    checks++;
    if (tick_o !== 1'b0 || div_clk_o !== 1'b0 || tick_count_o !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: tick=%b div=%b count=%0d, required 0 0 0",
               tick_o, div_clk_o, tick_count_o);
    end
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_low: ready=%b, required 0", ready_o);
    end
    reset_i = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_release: ready=%b, required 1", ready_o);
    end
  endtask

  task automatic test_default_ticks();
    logic       exp_tick;
    logic       exp_div;
    logic [7:0] exp_cnt;
    apply_reset();
    for (int e = 1; e <= 12; e++) begin
      step();
      exp_tick = (e % 4 == 0);
      exp_div  = 1'((e / 4) % 2);
      exp_cnt  = 8'(e / 4);
      checks++;
      if (tick_o !== exp_tick || div_clk_o !== exp_div || tick_count_o !== exp_cnt) begin
        errors++;
        $display("FAIL default_ticks edge %0d: tick=%b div=%b count=%0d, required %b %b %0d",
                 e, tick_o, div_clk_o, tick_count_o, exp_tick, exp_div, exp_cnt);
      end
    end
  endtask

  task automatic test_accept_zero();
    logic       exp_tick;
    logic       exp_div;
    logic [7:0] exp_cnt;
    apply_reset();
    v_i      = 1'b1;
    period_i = 8'd0;
    step();
    v_i = 1'b0;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL accept_zero_ready: ready=%b, required 0", ready_o);
    end
    for (int e = 2; e <= 12; e++) begin
      step();
      exp_tick = (e >= 4);
      exp_div  = (e >= 4) ? 1'((e - 3) % 2) : 1'b0;
      exp_cnt  = (e >= 4) ? 8'(e - 3) : 8'd0;
      checks++;
      if (tick_o !== exp_tick || div_clk_o !== exp_div || tick_count_o !== exp_cnt) begin
        errors++;
        $display("FAIL accept_zero edge %0d: tick=%b div=%b count=%0d, required %b %b %0d",
                 e, tick_o, div_clk_o, tick_count_o, exp_tick, exp_div, exp_cnt);
      end
    end
  endtask

  // Accept P=1 at edge 2; an offer of 7 at edge 3 must be ignored
  task automatic test_change_mid();
    logic exp_tick;
    logic exp_ready;
    apply_reset();
    for (int e = 1; e <= 10; e++) begin
      if (e == 2) begin
        v_i = 1'b1; period_i = 8'd1;
      end else if (e == 3) begin
        v_i = 1'b1; period_i = 8'd7;
      end else begin
        v_i = 1'b0; period_i = 8'd0;
      end
      step();
      exp_ready = !(e == 2 || e == 3);
      exp_tick  = (e == 4 || e == 6 || e == 8 || e == 10);
      checks++;
      if (ready_o !== exp_ready || tick_o !== exp_tick) begin
        errors++;
        $display("FAIL change_mid edge %0d: ready=%b tick=%b, required %b %b",
                 e, ready_o, tick_o, exp_ready, exp_tick);
      end
    end
    v_i = 1'b0;
  endtask

  // Accept P=7 on the wrap at edge 4: old period runs once more
  task automatic test_change_at_wrap();
    logic exp_tick;
    logic exp_ready;
    apply_reset();
    for (int e = 1; e <= 24; e++) begin
      if (e == 4) begin
        v_i = 1'b1; period_i = 8'd7;
      end else begin
        v_i = 1'b0; period_i = 8'd0;
      end
      step();
      exp_ready = !(e >= 4 && e <= 7);
      exp_tick  = (e == 4 || e == 8 || e == 16 || e == 24);
      checks++;
      if (ready_o !== exp_ready || tick_o !== exp_tick) begin
        errors++;
        $display("FAIL change_at_wrap edge %0d: ready=%b tick=%b, required %b %b",
                 e, ready_o, tick_o, exp_ready, exp_tick);
      end
    end
    v_i = 1'b0;
  endtask

  // Reset while PENDING discards the staged period
  task automatic test_reset_pending();
    logic exp_tick;
    apply_reset();
    step();
    v_i      = 1'b1;
    period_i = 8'd5;
    step();
    v_i = 1'b0;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_pending_accept: ready=%b, required 0", ready_o);
    end
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b1 || tick_count_o !== 8'd0 || tick_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_pending_release: ready=%b count=%0d tick=%b, required 1 0 0",
               ready_o, tick_count_o, tick_o);
    end
    for (int e = 1; e <= 12; e++) begin
      step();
      exp_tick = (e % 4 == 0);
      checks++;
      if (tick_o !== exp_tick || tick_count_o !== 8'(e / 4)) begin
        errors++;
        $display("FAIL reset_pending_run edge %0d: tick=%b count=%0d, required %b %0d",
                 e, tick_o, tick_count_o, exp_tick, e / 4);
      end
    end
  endtask

  // P=0 long run: tick count wraps 255 -> 0 with divider back at 0
  task automatic test_count_wrap();
    apply_reset();
    v_i      = 1'b1;
    period_i = 8'd0;
    step();
    v_i = 1'b0;
    for (int e = 2; e <= 258; e++) begin
      step();
    end
    checks++;
    if (tick_count_o !== 8'd255 || div_clk_o !== 1'b1 || tick_o !== 1'b1) begin
      errors++;
      $display("FAIL count_wrap_255: count=%0d div=%b tick=%b, required 255 1 1",
               tick_count_o, div_clk_o, tick_o);
    end
    step();
    checks++;
    if (tick_count_o !== 8'd0 || div_clk_o !== 1'b0 || tick_o !== 1'b1) begin
      errors++;
      $display("FAIL count_wrap_0: count=%0d div=%b tick=%b, required 0 0 1",
               tick_count_o, div_clk_o, tick_o);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset_i  = 1'b1;
    v_i      = 1'b0;
    period_i = 8'd0;
    test_reset();
    test_default_ticks();
    test_accept_zero();
    test_change_mid();
    test_change_at_wrap();
    test_reset_pending();
    test_count_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_nonsynth_clock_strobe_gen.md
BSG_NONSYNTH_CLOCK_STROBE_GEN -- requirements
Module: bsg_nonsynth_clock_strobe_gen

Interface
REQ-001 Parameter width_p, default 8: width of period_i and the internal period and cycle counter.
REQ-002 Parameter init_period_p, default 3: period register value after reset; SHALL be less than 2^width_p.
REQ-003 Parameter count_width_p, default 8: width of tick_count_o.
REQ-004 clk_i  input  1: single clock, driven by the nonsynth clock generator; all state SHALL update on its rising edge.
REQ-005 reset_i  input  1: reset, synchronous and active-high.
REQ-006 v_i  input  1: a new period is offered on period_i.
REQ-007 period_i  input  width_p: requested period value P; the tick interval is P+1 cycles.
REQ-008 ready_o  output  1: the block can accept a period this cycle.
REQ-009 tick_o  output  1: registered one-cycle strobe, once per period.
REQ-010 div_clk_o  output  1: registered divided clock that toggles on every tick.
REQ-011 tick_count_o  output  count_width_p: registered count of ticks since reset.

Function
REQ-012 Internal state SHALL be: period_r, cnt_r, pending_r, state_r in {RUN, PENDING}, tick_r, div_r, and count_r.
REQ-013 "Edge n" SHALL mean the n-th rising edge of clk_i at which reset_i is low; edge 1 is the first edge after reset release.
REQ-014 Wrap edge: an edge at which cnt_r == period_r; at a wrap edge the block SHALL set cnt_r to 0, tick_r to 1, invert div_r, and increment count_r modulo 2^count_width_p.
REQ-015 Non-wrap edge: the block SHALL increment cnt_r by 1 and clear tick_r to 0.
REQ-016 With period P, tick_o SHALL go high after edge P+1, then every P+1 edges, for exactly one cycle each time.
REQ-017 div_clk_o SHALL have a period of 2(P+1) cycles; with P=0, tick_o SHALL stay high continuously and div_clk_o SHALL toggle every cycle.
REQ-018 ready_o SHALL be 1 exactly when state_r == RUN and reset_i == 0; it is combinational from state_r and reset_i.
REQ-019 Accept: when v_i and ready_o are both high at an edge, the block SHALL store period_i into pending_r and move state_r to PENDING.
REQ-020 In PENDING, v_i SHALL be ignored.
REQ-021 At the first wrap edge after the accept edge, the block SHALL load pending_r into period_r and return state_r to RUN; cnt_r restarts at 0 under the new period.
REQ-022 The tick issued at that wrap edge SHALL still be produced.
REQ-023 Simultaneous accept and wrap edge in RUN: the wrap SHALL use the old period; the new period SHALL apply only at the next wrap edge, one full old period later.
REQ-024 A period change SHALL never shorten or truncate an in-progress interval, so div_clk_o remains glitch-free.
REQ-025 cnt_r SHALL never exceed period_r.
REQ-026 The block SHALL use no latches and no combinational path from v_i or period_i to any output.

Reset
REQ-027 While reset_i is high at an edge, the block SHALL set period_r=init_period_p, cnt_r=0, pending_r=0, state_r=RUN, tick_o=0, div_clk_o=0 and tick_count_o=0.
REQ-028 A reset during PENDING SHALL discard the pending period.
REQ-029 Before the first reset edge, output values are unspecified; the bench SHALL apply reset for at least 2 cycles.

Verification
REQ-030 Default parameters, 2 reset cycles, then release -> tick_o high after edges 4, 8 and 12; div_clk_o becomes 1 after edge 4 and 0 after edge 8; tick_count_o equals 3 after edge 12.
REQ-031 Accept period_i=0 at edge 1, then run -> the first wrap (edge 4) applies P=0; tick_o stays high continuously from edge 4 onward and div_clk_o toggles every cycle.
REQ-032 P=3, accept period_i=1 at edge 2 -> ready_o is low after edges 2 through 3 and high again after edge 4; the next ticks follow edges 6, 8 and 10.
REQ-033 P=3, accept period_i=7 at edge 4 (a wrap edge) -> ticks follow edges 4, 8 and 16, with an 8-cycle spacing thereafter.
REQ-034 Accept period_i=5 at edge 2, then assert reset_i at edge 3 -> after release, ready_o=1, tick_count_o=0, and ticks resume every 4 cycles.
REQ-035 P=0 and count_width_p=8, run 256 edges -> tick_count_o wraps from 255 to 0 and div_clk_o ends at 0.
